tlul_err_resp_multi: RTL and testbench

Parametrised TL-UL error/default responder that terminates requests decoded to no valid target, with multiple outstanding requests. It is the next generation of the single-entry error responder and sits on the unmapped-address port of `tlul_socket_1n` and crossbar default routes. It generalises to a configurable queue of pending responses, adds a configurable response pattern and a benign default-slave mode, and keeps error statistics: a saturating count plus first-offender capture for debug CSRs.

---
 rtl/tlul_pkg.sv | 59 +++++
 rtl/tlul_err_fifo.sv | 67 ++++++
 rtl/tlul_err_resp_multi.sv | 88 ++++++++
 tb/tb_tlul_err_resp_multi.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: TL-UL widths, opcodes, channel structs and the error-responder queue entry.
// Rev 1.1
`default_nettype none
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tlul_a_m_op;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tlul_d_m_op;

  typedef struct packed {
    logic              a_valid;
    tlul_a_m_op        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tlul_d_m_op        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tlul_d2h_t;

  typedef struct packed {
    logic [TL_AIW-1:0] source;
    logic [TL_SZW-1:0] size;
    tlul_a_m_op        opcode;
  } tlul_err_entry_t;

  function automatic tlul_d_m_op rsp_opcode(input tlul_a_m_op op);
    return (op == Get) ? AccessAckData : AccessAck;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlul_err_fifo.sv
// tlul_err_fifo: synchronous FIFO of pending error-response entries.
// Rev 1.1
`default_nettype none
module tlul_err_fifo
  import tlul_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wvalid,
  input  tlul_err_entry_t wdata,
  input  logic            rready,
  output tlul_err_entry_t rdata,
  output logic            full,
  output logic            empty
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int OccW = $clog2(Depth + 1);

  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [OccW-1:0] occ;
  logic            push;
  logic            pop;
  tlul_err_entry_t mem [Depth];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (occ == OccW'(Depth));
  assign empty = (occ == '0);
  // Push is gated by full only, so a pop never frees a slot in the same cycle.
  assign push  = wvalid && !full;
  assign pop   = rready && !empty;
  assign rdata = mem[rptr];

  for (genvar i = 0; i < Depth; i++) begin : g_mem
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem[i] <= '0;
      end else if (push && (wptr == PtrW'(i))) begin
        mem[i] <= wdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlul_err_resp_multi.sv
// tlul_err_resp_multi: multi-outstanding TL-UL error/default responder with error statistics.
// Rev 1.1
`default_nettype none
module tlul_err_resp_multi
  import tlul_pkg::*;
#(
  parameter int               Depth   = 2,
  parameter logic [TL_DW-1:0] RspData = 32'hFFFF_FFFF,
  parameter bit               ErrEn   = 1'b1,
  parameter int               CntW    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tlul_h2d_t         tl_h_i,
  output tlul_d2h_t         tl_h_o,
  input  logic              clr_i,
  output logic [CntW-1:0]   err_cnt_o,
  output logic [TL_AW-1:0]  err_addr_o,
  output logic [TL_AIW-1:0] err_src_o,
  output logic              err_vld_o
);

  tlul_err_entry_t push_entry;
  tlul_err_entry_t head;
  logic            full;
  logic            empty;
  logic            accept;
  logic            unused_a;

  assign accept     = tl_h_i.a_valid && !full;
  assign push_entry = '{source: tl_h_i.a_source, size: tl_h_i.a_size, opcode: tl_h_i.a_opcode};
  assign unused_a   = ^{tl_h_i.a_param, tl_h_i.a_mask, tl_h_i.a_data};

  tlul_err_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wvalid (tl_h_i.a_valid),
    .wdata  (push_entry),
    .rready (tl_h_i.d_ready),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    tl_h_o          = '0;
    tl_h_o.a_ready  = !full;
    tl_h_o.d_valid  = !empty;
    tl_h_o.d_opcode = rsp_opcode(head.opcode);
    tl_h_o.d_param  = '0;
    tl_h_o.d_size   = head.size;
    tl_h_o.d_source = head.source;
    tl_h_o.d_sink   = '0;
    tl_h_o.d_data   = (head.opcode == Get) ? RspData : '0;
    tl_h_o.d_error  = ErrEn;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o <= '0;
    end else if (clr_i) begin
      err_cnt_o <= accept ? CntW'(1) : '0;
    end else if (accept && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

  // Clear takes priority over the held entry, so a coincident accept becomes the new first offender.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_vld_o  <= 1'b0;
      err_addr_o <= '0;
      err_src_o  <= '0;
    end else if (accept && (clr_i || !err_vld_o)) begin
      err_vld_o  <= 1'b1;
      err_addr_o <= tl_h_i.a_address;
      err_src_o  <= tl_h_i.a_source;
    end else if (clr_i) begin
      err_vld_o  <= 1'b0;
      err_addr_o <= '0;
      err_src_o  <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlul_err_resp_multi.sv
// tb_tlul_err_resp_multi: directed self-checking bench for the multi-entry error responder.
// Rev 1.1
`default_nettype none
module tb_tlul_err_resp_multi;
  import tlul_pkg::*;

  logic        clk;
  logic        rst_n;
  tlul_h2d_t   ha;
  tlul_d2h_t   da;
  logic        clr_a;
  logic [15:0] cnt_a;
  logic [31:0] addr_a;
  logic [7:0]  src_a;
  logic        vld_a;
  tlul_h2d_t   hb;
  tlul_d2h_t   db;
  logic        clr_b;
  logic [3:0]  cnt_b;
  logic [31:0] addr_b;
  logic [7:0]  src_b;
  logic        vld_b;

  int checks   = 0;
  int failures = 0;
  int acc;
  int sent;
  int rsp;
  int cyc;

  tlul_err_resp_multi dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(ha), .tl_h_o(da), .clr_i(clr_a),
    .err_cnt_o(cnt_a), .err_addr_o(addr_a), .err_src_o(src_a), .err_vld_o(vld_a)
  );

  tlul_err_resp_multi #(
    .Depth(2), .RspData(32'h0), .ErrEn(1'b0), .CntW(4)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tl_h_i(hb), .tl_h_o(db), .clr_i(clr_b),
    .err_cnt_o(cnt_b), .err_addr_o(addr_b), .err_src_o(src_b), .err_vld_o(vld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ha = '0; hb = '0; clr_a = 1'b0; clr_b = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_a_ready", da.a_ready, 1);
    chk("rst_d_valid", da.d_valid, 0);
    chk("rst_d_opcode", da.d_opcode, AccessAck);
    chk("rst_d_source", da.d_source, 0);
    chk("rst_d_data", da.d_data, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_addr", addr_a, 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // single Get
    ha.a_valid = 1'b1; ha.a_opcode = Get; ha.a_source = 8'd3; ha.a_size = 2'd2;
    ha.a_address = 32'h1000; ha.d_ready = 1'b1;
    @(negedge clk);
    chk("get_a_ready", da.a_ready, 1);
    chk("get_no_comb_rsp", da.d_valid, 0);
    next_cycle();
    ha.a_valid = 1'b0;
    @(negedge clk);
    chk("get_d_valid", da.d_valid, 1);
    chk("get_d_opcode", da.d_opcode, AccessAckData);
    chk("get_d_data", da.d_data, 32'hFFFF_FFFF);
    chk("get_d_source", da.d_source, 3);
    chk("get_d_size", da.d_size, 2);
    chk("get_d_error", da.d_error, 1);
    chk("get_cnt", cnt_a, 1);
    chk("get_vld", vld_a, 1);
    chk("get_addr", addr_a, 32'h1000);
    chk("get_src", src_a, 3);
    next_cycle();
    chk("get_popped", da.d_valid, 0);

    // backpressure: 5 PutFull attempts with d_ready low
    ha.d_ready = 1'b0; ha.a_opcode = PutFullData; ha.a_size = 2'd1;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      ha.a_valid = 1'b1; ha.a_source = 8'(5 + acc); ha.a_address = 32'h3000;
      @(negedge clk);
      if (da.a_ready) acc++;
      next_cycle();
    end
    ha.a_valid = 1'b0;
    chk("bp_accepted", acc, 2);
    chk("bp_a_ready", da.a_ready, 0);
    chk("bp_head_stall", da.d_source, 5);
    ha.d_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp0_src", da.d_source, 5);
    chk("bp_rsp0_op", da.d_opcode, AccessAck);
    chk("bp_rsp0_data", da.d_data, 0);
    chk("bp_full_pop_a_ready", da.a_ready, 0);
    next_cycle();
    chk("bp_rsp1_valid", da.d_valid, 1);
    chk("bp_rsp1_src", da.d_source, 6);
    chk("bp_rsp1_ready", da.a_ready, 1);
    next_cycle();
    chk("bp_drained", da.d_valid, 0);
    chk("bp_cnt", cnt_a, 3);
    chk("bp_first_kept", addr_a, 32'h1000);

    // streaming 100 Gets, clr coincident with the first accept
    ha.a_opcode = Get; ha.a_size = 2'd2;
    sent = 0; rsp = 0; cyc = 0;
    while (rsp < 100 && cyc < 200) begin
      ha.a_valid = (sent < 100);
      ha.a_source = 8'(sent);
      ha.a_address = 32'h2000 + 32'(sent * 4);
      clr_a = (cyc == 0);
      @(negedge clk);
      if (da.d_valid) begin
        chk("stream_src", da.d_source, 8'(rsp));
        rsp++;
      end
      if (ha.a_valid && da.a_ready) sent++;
      cyc++;
      next_cycle();
    end
    ha.a_valid = 1'b0; clr_a = 1'b0;
    chk("stream_rsps", rsp, 100);
    chk("stream_cycles", cyc, 101);
    chk("stream_cnt", cnt_a, 100);
    chk("stream_addr", addr_a, 32'h2000);
    chk("stream_src_cap", src_a, 0);
    chk("stream_vld", vld_a, 1);

    // silent default slave, narrow saturating counter
    hb.d_ready = 1'b1; hb.a_valid = 1'b1; hb.a_opcode = Get; hb.a_source = 8'd9;
    hb.a_size = 2'd2; hb.a_address = 32'h100;
    next_cycle();
    hb.a_valid = 1'b0;
    @(negedge clk);
    chk("b_d_valid", db.d_valid, 1);
    chk("b_d_opcode", db.d_opcode, AccessAckData);
    chk("b_d_data", db.d_data, 0);
    chk("b_d_error", db.d_error, 0);
    chk("b_cnt1", cnt_b, 1);
    next_cycle();
    hb.a_valid = 1'b1; hb.a_address = 32'h200;
    for (int i = 0; i < 19; i++) next_cycle();
    hb.a_valid = 1'b0;
    chk("b_cnt_sat", cnt_b, 15);
    chk("b_addr_first", addr_b, 32'h100);
    hb.a_valid = 1'b1; hb.a_address = 32'h40; hb.a_source = 8'd4; clr_b = 1'b1;
    next_cycle();
    hb.a_valid = 1'b0; clr_b = 1'b0;
    chk("b_clr_cnt", cnt_b, 1);
    chk("b_clr_addr", addr_b, 32'h40);
    chk("b_clr_vld", vld_b, 1);
    next_cycle();

    // async reset with two pending responses
    ha.d_ready = 1'b0; ha.a_valid = 1'b1; ha.a_source = 8'd7;
    next_cycle();
    ha.a_source = 8'd8;
    next_cycle();
    ha.a_valid = 1'b0;
    chk("pre_rst_valid", da.d_valid, 1);
    chk("pre_rst_full", da.a_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_d_valid", da.d_valid, 0);
    chk("async_rst_a_ready", da.a_ready, 1);
    chk("async_rst_cnt", cnt_a, 0);
    chk("async_rst_vld", vld_a, 0);
    next_cycle();
    rst_n = 1'b1; ha.d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", da.d_valid, 0);
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
